// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: RV32I width codes,
// the sequencing FSM state type and the lane mask / legality helpers.
package lsu_pkg;

    localparam logic [2:0] W_B  = 3'b000;
    localparam logic [2:0] W_H  = 3'b001;
    localparam logic [2:0] W_W  = 3'b010;
    localparam logic [2:0] W_BU = 3'b100;
    localparam logic [2:0] W_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BEAT0   = 3'd1,
        BEAT1   = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } lsu_state_t;

    // Right-justified byte-lane mask for an access width; zero for illegal codes.
    function automatic logic [3:0] width_mask(input logic [2:0] width);
        logic [3:0] m;
        case (width)
            W_B, W_BU: m = 4'b0001;
            W_H, W_HU: m = 4'b0011;
            W_W:       m = 4'b1111;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

    // Unsigned widths only make sense for loads.
    function automatic logic width_illegal(input logic [2:0] width, input logic write);
        logic bad;
        case (width)
            W_B, W_H, W_W: bad = 1'b0;
            W_BU, W_HU:    bad = write;
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

    // An access splits when its lanes run past byte 3 of the first word.
    function automatic logic needs_split(input logic [2:0] width, input logic [1:0] off);
        logic s;
        case (width)
            W_H, W_HU: s = (off == 2'd3);
            W_W:       s = (off != 2'd0);
            default:   s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response port from the execute stage and the word-organised
// memory port. The execute stage is master of lsu_req_if; the unit is
// master of lsu_mem_if.
interface lsu_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_width;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_misaligned;
    logic              resp_error;

    modport master (
        output req_valid, req_write, req_width, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_width, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_error
    );
endinterface

interface lsu_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W/8-1:0] mem_be;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;

    modport master (
        output mem_en, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Load-side lane merge: picks the addressed bytes out of the two-word window
// {hi, lo} and sign/zero-extends them. Purely combinational so it can also
// sit on a store-to-load forwarding path.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    input  logic [1:0]  off,
    input  logic [2:0]  width,
    output logic [31:0] rdata
);

    logic [63:0] pair;
    logic [31:0] raw;

    // Shift the window down by the byte offset, then extend per width code.
    always_comb begin
        pair = {hi, lo} >> {off, 3'b000};
        raw  = pair[31:0];
        case (width)
            W_B:     rdata = {{24{raw[7]}}, raw[7:0]};
            W_H:     rdata = {{16{raw[15]}}, raw[15:0]};
            W_BU:    rdata = {24'h0, raw[7:0]};
            W_HU:    rdata = {16'h0, raw[15:0]};
            default: rdata = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, issues one or two aligned
// word beats with byte enables, merges load lanes and returns a one-cycle
// registered response.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a request; no beat driven
//   BEAT0   | first (or only) word beat on the memory port
//   BEAT1   | second beat of a split access; beat0 read data captured
//   CAPTURE | last read data on mem_rdata; response computed
//   RESP    | resp_valid pulse
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)(
    input  logic      clk,
    input  logic      reset_n,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    lsu_state_t        state;
    logic              write_q;
    logic [2:0]        width_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] wdata_q;
    logic              split_q;
    logic [31:0]       lo_buf;
    logic [31:0]       hi_buf;

    logic              accept;
    logic [2:0]        src_width;
    logic [1:0]        src_off;
    logic [DATA_W-1:0] src_wdata;
    logic [7:0]        be_pair;
    logic [63:0]       wdata_pair;
    logic [31:0]       align_lo;
    logic [31:0]       align_hi;
    logic [31:0]       load_data;

    assign req.req_ready = (state == IDLE);
    assign accept        = req.req_valid && req.req_ready;

    // Lane enables and data for both beats at once: the low nibble/word is
    // beat0, the high nibble/word is what spills into beat1. In IDLE the
    // live request is used so beat0 can be driven right after the accept.
    always_comb begin
        src_width = width_q;
        src_off   = off_q;
        src_wdata = wdata_q;
        if (state == IDLE) begin
            src_width = req.req_width;
            src_off   = req.req_addr[1:0];
            src_wdata = req.req_wdata;
        end
        be_pair    = {4'b0000, width_mask(src_width)} << src_off;
        wdata_pair = {32'h0, src_wdata} << {src_off, 3'b000};
    end

    // In CAPTURE the last word is still on mem_rdata, so it feeds the
    // aligner directly rather than waiting a cycle for the buffer.
    assign align_lo = split_q ? lo_buf : mem.mem_rdata;
    assign align_hi = split_q ? mem.mem_rdata : hi_buf;

    lsu_lane_align u_align (
        .lo    (align_lo),
        .hi    (align_hi),
        .off   (off_q),
        .width (width_q),
        .rdata (load_data)
    );

    // Sequencing FSM with registered beat and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= IDLE;
            write_q              <= 1'b0;
            width_q              <= 3'b000;
            off_q                <= 2'b00;
            wdata_q              <= '0;
            split_q              <= 1'b0;
            lo_buf               <= 32'h0;
            hi_buf               <= 32'h0;
            mem.mem_en           <= 1'b0;
            mem.mem_we           <= 1'b0;
            mem.mem_addr         <= '0;
            mem.mem_be           <= '0;
            mem.mem_wdata        <= '0;
            req.resp_valid       <= 1'b0;
            req.resp_rdata       <= '0;
            req.resp_misaligned  <= 1'b0;
            req.resp_error       <= 1'b0;
        end else begin
            mem.mem_en          <= 1'b0;
            mem.mem_we          <= 1'b0;
            mem.mem_addr        <= '0;
            mem.mem_be          <= '0;
            mem.mem_wdata       <= '0;
            req.resp_valid      <= 1'b0;
            req.resp_rdata      <= '0;
            req.resp_misaligned <= 1'b0;
            req.resp_error      <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        write_q <= req.req_write;
                        width_q <= req.req_width;
                        off_q   <= req.req_addr[1:0];
                        wdata_q <= req.req_wdata;
                        split_q <= needs_split(req.req_width, req.req_addr[1:0]);
                        if (width_illegal(req.req_width, req.req_write)) begin
                            state          <= RESP;
                            req.resp_valid <= 1'b1;
                            req.resp_error <= 1'b1;
                        end else begin
                            state         <= BEAT0;
                            mem.mem_en    <= 1'b1;
                            mem.mem_we    <= req.req_write;
                            mem.mem_addr  <= {req.req_addr[ADDR_W-1:2], 2'b00};
                            mem.mem_be    <= be_pair[3:0];
                            mem.mem_wdata <= wdata_pair[31:0];
                        end
                    end
                end
                BEAT0: begin
                    if (split_q) begin
                        state         <= BEAT1;
                        mem.mem_en    <= 1'b1;
                        mem.mem_we    <= write_q;
                        mem.mem_addr  <= mem.mem_addr + ADDR_W'(4);
                        mem.mem_be    <= be_pair[7:4];
                        mem.mem_wdata <= wdata_pair[63:32];
                    end else begin
                        state <= CAPTURE;
                    end
                end
                BEAT1: begin
                    lo_buf <= mem.mem_rdata;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    if (split_q) hi_buf <= mem.mem_rdata;
                    else         lo_buf <= mem.mem_rdata;
                    state               <= RESP;
                    req.resp_valid      <= 1'b1;
                    req.resp_misaligned <= split_q;
                    req.resp_rdata      <= write_q ? 32'h0 : load_data;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 1-cycle synchronous-read memory.
module tb_load_store_unit;

    logic clk;
    logic reset_n;

    lsu_req_if rq ();
    lsu_mem_if mm ();

    load_store_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (rq),
        .mem     (mm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory, 64 words, byte-enabled writes, registered read.
    logic [31:0] mem_arr [0:63];
    always @(posedge clk) begin
        if (mm.mem_en) begin
            mm.mem_rdata <= mem_arr[mm.mem_addr[7:2]];
            if (mm.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mm.mem_be[b]) mem_arr[mm.mem_addr[7:2]][8*b +: 8] <= mm.mem_wdata[8*b +: 8];
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] got_rdata;
    logic        got_mis;
    logic        got_err;
    int          got_lat;
    int          nbeats;
    int          en_seen;
    logic [31:0] beat_addr  [2];
    logic [3:0]  beat_be    [2];
    logic [31:0] beat_wdata [2];
    logic        beat_we    [2];

    // Issue one request at a negedge; accept edge is the following posedge.
    // got_lat counts edges after the accept edge up to the resp_valid cycle.
    task automatic do_req(input logic wr, input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
        got_rdata = 32'h0; got_mis = 1'b0; got_err = 1'b0; got_lat = 0; nbeats = 0; en_seen = 0;
        @(negedge clk);
        rq.req_valid = 1'b1; rq.req_write = wr; rq.req_width = w; rq.req_addr = a; rq.req_wdata = d;
        @(posedge clk);
        #1 rq.req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mm.mem_en) begin
                en_seen++;
                if (nbeats < 2) begin
                    beat_addr[nbeats]  = mm.mem_addr;
                    beat_be[nbeats]    = mm.mem_be;
                    beat_wdata[nbeats] = mm.mem_wdata;
                    beat_we[nbeats]    = mm.mem_we;
                end
                nbeats++;
            end
            if (rq.resp_valid) begin
                got_rdata = rq.resp_rdata; got_mis = rq.resp_misaligned;
                got_err = rq.resp_error; got_lat = k;
                break;
            end
        end
    endtask

    typedef struct {
        logic [2:0]  w;
        logic [31:0] a;
        logic [31:0] exp;
        string       tag;
    } load_vec_t;

    load_vec_t lv [4];

    initial begin
        rq.req_valid = 1'b0; rq.req_write = 1'b0; rq.req_width = 3'b000;
        rq.req_addr = 32'h0; rq.req_wdata = 32'h0;
        for (int i = 0; i < 64; i++) mem_arr[i] = 32'h0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready",  {31'h0, rq.req_ready},  32'h1);
        check("rst_mem_en", {31'h0, mm.mem_en},     32'h0);
        check("rst_resp",   {31'h0, rq.resp_valid}, 32'h0);
        reset_n = 1'b1;

        // Aligned word store then load.
        do_req(1'b1, 3'b010, 32'h10, 32'h2345_6789);
        check("sw_lat",   got_lat, 3);
        check("sw_beats", nbeats, 1);
        check("sw_be",    {28'h0, beat_be[0]}, 32'hF);
        check("sw_wdata", beat_wdata[0], 32'h2345_6789);
        check("sw_rdata", got_rdata, 32'h0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        check("lw_lat",   got_lat, 3);
        check("lw_addr",  beat_addr[0], 32'h10);
        check("lw_rdata", got_rdata, 32'h2345_6789);
        check("lw_mis",   {31'h0, got_mis}, 32'h0);

        // Byte stores into each lane of 0x20.
        for (int i = 0; i < 4; i++) begin
            logic [31:0] bytes;
            logic [3:0]  exp_be;
            bytes  = 32'h2345_6789;
            exp_be = 4'b0001 << i;
            do_req(1'b1, 3'b000, 32'h20 + 32'(i), {24'h0, bytes[8*i +: 8]});
            check($sformatf("sb%0d_be", i), {28'h0, beat_be[0]}, {28'h0, exp_be});
        end
        do_req(1'b0, 3'b010, 32'h20, 32'h0);
        check("lw20_rdata", got_rdata, 32'h2345_6789);

        // Sign/zero extension.
        do_req(1'b1, 3'b010, 32'h14, 32'hF0F0_F0F0);
        lv[0] = '{3'b000, 32'h14, 32'hFFFF_FFF0, "lb"};
        lv[1] = '{3'b100, 32'h14, 32'h0000_00F0, "lbu"};
        lv[2] = '{3'b001, 32'h16, 32'hFFFF_F0F0, "lh"};
        lv[3] = '{3'b101, 32'h16, 32'h0000_F0F0, "lhu"};
        foreach (lv[i]) begin
            do_req(1'b0, lv[i].w, lv[i].a, 32'h0);
            check(lv[i].tag, got_rdata, lv[i].exp);
        end

        // Split word load across 0x20/0x24.
        do_req(1'b1, 3'b010, 32'h24, 32'hAABB_CCDD);
        do_req(1'b0, 3'b010, 32'h21, 32'h0);
        check("lwx_beats", nbeats, 2);
        check("lwx_addr0", beat_addr[0], 32'h20);
        check("lwx_addr1", beat_addr[1], 32'h24);
        check("lwx_be0",   {28'h0, beat_be[0]}, 32'hE);
        check("lwx_be1",   {28'h0, beat_be[1]}, 32'h1);
        check("lwx_lat",   got_lat, 4);
        check("lwx_rdata", got_rdata, 32'hDD23_4567);
        check("lwx_mis",   {31'h0, got_mis}, 32'h1);

        // Split halfword store at 0x23 and read back.
        do_req(1'b1, 3'b001, 32'h23, 32'h0000_BEEF);
        check("shx_addr0",  beat_addr[0], 32'h20);
        check("shx_be0",    {28'h0, beat_be[0]}, 32'h8);
        check("shx_wd0",    {24'h0, beat_wdata[0][31:24]}, 32'hEF);
        check("shx_addr1",  beat_addr[1], 32'h24);
        check("shx_be1",    {28'h0, beat_be[1]}, 32'h1);
        check("shx_wd1",    {24'h0, beat_wdata[1][7:0]}, 32'hBE);
        check("shx_we1",    {31'h0, beat_we[1]}, 32'h1);
        do_req(1'b0, 3'b101, 32'h23, 32'h0);
        check("lhux_rdata", got_rdata, 32'h0000_BEEF);
        check("lhux_lat",   got_lat, 4);

        // Illegal widths.
        do_req(1'b0, 3'b011, 32'h10, 32'h0);
        check("err_lat",   got_lat, 1);
        check("err_flag",  {31'h0, got_err}, 32'h1);
        check("err_en",    en_seen, 0);
        check("err_rdata", got_rdata, 32'h0);
        do_req(1'b1, 3'b100, 32'h10, 32'h0);
        check("sbu_err",   {31'h0, got_err}, 32'h1);
        check("sbu_en",    en_seen, 0);

        // Reset asserted while the second beat is on the bus.
        @(negedge clk);
        rq.req_valid = 1'b1; rq.req_write = 1'b0; rq.req_width = 3'b010; rq.req_addr = 32'h21;
        @(posedge clk);
        #1 rq.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_b1_en", {31'h0, mm.mem_en}, 32'h1);
        #1 reset_n = 1'b0;
        #1 check("rst_b1_drop", {31'h0, mm.mem_en}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        begin
            int resp_seen;
            resp_seen = 0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (rq.resp_valid) resp_seen++;
            end
            check("rst_no_resp", resp_seen, 0);
        end
        check("rst_ready_after", {31'h0, rq.req_ready}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
